gmii_frame_gen: RTL and testbench

//  Synthesizable N-port GMII receive-side frame generator. Replaces the static rxdv/rxer/rxd tie-offs on the Ethernet ports.

---
 rtl/gmii_frame_gen_pkg.sv | 47 ++++
 rtl/gmii_frame_gen_if.sv | 28 ++
 rtl/gmii_frame_gen_port.sv | 184 ++++++++++++++++++
 rtl/gmii_frame_gen.sv | 53 +++++
 tb/tb_gmii_frame_gen.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gmii_frame_gen_pkg.sv
// Shared types, constants and helper functions for the GMII receive-side frame generator.
// The CRC helper is also used by the verification environment.
package gmii_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_PAY  = 3'd3,
    ST_FCS  = 3'd4,
    ST_IFG  = 3'd5
  } gen_state_e;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_INC2  = 2'd3
  } gen_mode_e;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam int          PRE_LEN     = 7;

  // Reflected CRC32, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] prbs8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/gmii_frame_gen_if.sv
// Request/response bundle between the stimulus side (master) and the frame generator (slave).
interface gmii_frame_gen_if #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_W     = 11,
  parameter int CNT_W     = 16
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0][LEN_W-1:0] req_len;
  logic [NUM_PORTS-1:0][1:0]       req_mode;
  logic [NUM_PORTS-1:0][7:0]       req_seed;
  logic [NUM_PORTS-1:0]            req_bad_fcs;
  logic [NUM_PORTS-1:0]            req_rxer;
  logic [NUM_PORTS-1:0]            rxdv;
  logic [NUM_PORTS-1:0]            rxer;
  logic [NUM_PORTS-1:0][7:0]       rxd;
  logic [NUM_PORTS-1:0][CNT_W-1:0] frame_cnt;

  modport master (
    output req_valid, req_len, req_mode, req_seed, req_bad_fcs, req_rxer,
    input  req_ready, rxdv, rxer, rxd, frame_cnt
  );

  modport slave (
    input  req_valid, req_len, req_mode, req_seed, req_bad_fcs, req_rxer,
    output req_ready, rxdv, rxer, rxd, frame_cnt
  );
endinterface

// File: rtl/gmii_frame_gen_port.sv
// One independent GMII frame generator: FSM, payload pattern, running CRC32 and frame counter.
module gmii_gen_port
  import gmii_gen_pkg::*;
#(
  parameter int LEN_W     = 11,
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1514,
  parameter int IFG_BYTES = 12,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [LEN_W-1:0] i_req_len,
  input  logic [1:0]       i_req_mode,
  input  logic [7:0]       i_req_seed,
  input  logic             i_req_bad_fcs,
  input  logic             i_req_rxer,
  output logic             o_rxdv,
  output logic             o_rxer,
  output logic [7:0]       o_rxd,
  output logic [CNT_W-1:0] o_frame_cnt
);

  gen_state_e       r_state;
  gen_mode_e        r_mode;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [7:0]       r_pat;
  logic [31:0]      r_crc;
  logic             r_bad_fcs;
  logic             r_rxer_en;
  logic             r_ready;
  logic             r_rxdv;
  logic             r_rxer;
  logic [7:0]       r_rxd;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_accept;
  logic [31:0]      w_fcs;
  logic [7:0]       w_pat_next;
  logic [7:0]       w_fcs_byte;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len < LEN_W'(MIN_LEN)) begin
      return LEN_W'(MIN_LEN);
    end else if (len > LEN_W'(MAX_LEN)) begin
      return LEN_W'(MAX_LEN);
    end else begin
      return len;
    end
  endfunction

  assign w_accept = i_req_valid && r_ready;
  assign w_fcs    = ~r_crc;

  // Next payload byte for the latched pattern mode.
  always_comb begin
    w_pat_next = r_pat + 8'd1;
    case (r_mode)
      MODE_PRBS:  w_pat_next = prbs8_next(r_pat);
      MODE_CONST: w_pat_next = r_pat;
      default:    w_pat_next = r_pat + 8'd1;
    endcase
  end

  // FCS byte selection; bad_fcs flips bit 0 of the final byte.
  always_comb begin
    w_fcs_byte = w_fcs[7:0];
    case (r_cnt[1:0])
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      2'd3:    w_fcs_byte = {w_fcs[31:25], w_fcs[24] ^ r_bad_fcs};
      default: w_fcs_byte = w_fcs[7:0];
    endcase
  end

  // Frame FSM; every output is registered and computed one cycle ahead of the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_INC;
      r_len       <= LEN_W'(MIN_LEN);
      r_cnt       <= '0;
      r_pat       <= 8'h00;
      r_crc       <= CRC_INIT;
      r_bad_fcs   <= 1'b0;
      r_rxer_en   <= 1'b0;
      r_ready     <= 1'b1;
      r_rxdv      <= 1'b0;
      r_rxer      <= 1'b0;
      r_rxd       <= 8'h00;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rxer <= 1'b0;
          if (w_accept) begin
            r_state   <= ST_PRE;
            r_ready   <= 1'b0;
            r_rxdv    <= 1'b1;
            r_rxd     <= PREAMBLE;
            r_cnt     <= LEN_W'(1);
            r_len     <= clamp_len(i_req_len);
            r_mode    <= gen_mode_e'(i_req_mode);
            r_pat     <= ((gen_mode_e'(i_req_mode) == MODE_PRBS) && (i_req_seed == 8'h00)) ?
                         8'h01 : i_req_seed;
            r_bad_fcs <= i_req_bad_fcs;
            r_rxer_en <= i_req_rxer;
          end else begin
            r_ready <= 1'b1;
            r_rxdv  <= 1'b0;
            r_rxd   <= 8'h00;
          end
        end
        ST_PRE: begin
          if (r_cnt == LEN_W'(PRE_LEN)) begin
            r_state <= ST_SFD;
            r_rxd   <= SFD;
          end else begin
            r_rxd <= PREAMBLE;
            r_cnt <= r_cnt + LEN_W'(1);
          end
        end
        ST_SFD: begin
          r_state <= ST_PAY;
          r_rxd   <= r_pat;
          r_rxer  <= r_rxer_en;
          r_crc   <= crc32_byte(CRC_INIT, r_pat);
          r_pat   <= w_pat_next;
          r_cnt   <= LEN_W'(1);
        end
        ST_PAY: begin
          r_rxer <= 1'b0;
          if (r_cnt == r_len) begin
            r_state <= ST_FCS;
            r_rxd   <= w_fcs[7:0];
            r_cnt   <= LEN_W'(1);
          end else begin
            r_rxd <= r_pat;
            r_crc <= crc32_byte(r_crc, r_pat);
            r_pat <= w_pat_next;
            r_cnt <= r_cnt + LEN_W'(1);
          end
        end
        ST_FCS: begin
          if (r_cnt == LEN_W'(4)) begin
            r_state     <= ST_IFG;
            r_rxdv      <= 1'b0;
            r_rxd       <= 8'h00;
            r_cnt       <= LEN_W'(1);
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          end else begin
            r_rxd <= w_fcs_byte;
            r_cnt <= r_cnt + LEN_W'(1);
          end
        end
        ST_IFG: begin
          if (r_cnt == LEN_W'(IFG_BYTES)) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + LEN_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_rxdv  <= 1'b0;
          r_rxer  <= 1'b0;
          r_rxd   <= 8'h00;
        end
      endcase
    end
  end

  assign o_req_ready = r_ready;
  assign o_rxdv      = r_rxdv;
  assign o_rxer      = r_rxer;
  assign o_rxd       = r_rxd;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: rtl/gmii_frame_gen.sv
// N-port GMII receive-side frame generator; each port is a fully independent gmii_gen_port.
module gmii_frame_gen
  import gmii_gen_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int LEN_W     = 11,
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1514,
  parameter int IFG_BYTES = 12,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  gmii_frame_gen_if.slave bus
);

  logic [NUM_PORTS-1:0]            w_req_ready;
  logic [NUM_PORTS-1:0]            w_rxdv;
  logic [NUM_PORTS-1:0]            w_rxer;
  logic [NUM_PORTS-1:0][7:0]       w_rxd;
  logic [NUM_PORTS-1:0][CNT_W-1:0] w_frame_cnt;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    gmii_gen_port #(
      .LEN_W     (LEN_W),
      .MIN_LEN   (MIN_LEN),
      .MAX_LEN   (MAX_LEN),
      .IFG_BYTES (IFG_BYTES),
      .CNT_W     (CNT_W)
    ) u_port (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (bus.req_valid[g]),
      .o_req_ready   (w_req_ready[g]),
      .i_req_len     (bus.req_len[g]),
      .i_req_mode    (bus.req_mode[g]),
      .i_req_seed    (bus.req_seed[g]),
      .i_req_bad_fcs (bus.req_bad_fcs[g]),
      .i_req_rxer    (bus.req_rxer[g]),
      .o_rxdv        (w_rxdv[g]),
      .o_rxer        (w_rxer[g]),
      .o_rxd         (w_rxd[g]),
      .o_frame_cnt   (w_frame_cnt[g])
    );
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rxdv      = w_rxdv;
  assign bus.rxer      = w_rxer;
  assign bus.rxd       = w_rxd;
  assign bus.frame_cnt = w_frame_cnt;

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Scoreboard bench: requests push expected byte streams; a negedge monitor pops and compares them.
module tb_gmii_frame_gen;
  import gmii_gen_pkg::*;

  localparam int NP      = 4;
  localparam int NS      = 5;
  localparam int IFG     = 12;
  localparam int GAP_EXP = 60 + 12 + IFG + 1;

  typedef struct packed {
    logic [31:0] len;
    logic        good;
  } frm_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  gmii_frame_gen_if #(.NUM_PORTS(4), .LEN_W(11), .CNT_W(16)) u_if ();
  gmii_frame_gen_if #(.NUM_PORTS(1), .LEN_W(11), .CNT_W(2))  u_if2 ();

  gmii_frame_gen #(.NUM_PORTS(4), .LEN_W(11), .MIN_LEN(60), .MAX_LEN(1514),
                   .IFG_BYTES(IFG), .CNT_W(16))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if));

  gmii_frame_gen #(.NUM_PORTS(1), .LEN_W(11), .MIN_LEN(60), .MAX_LEN(1514),
                   .IFG_BYTES(IFG), .CNT_W(2))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2));

  always #4 clk = ~clk;

  // stream 4 is the single port of the 2-bit-counter instance
  logic [NS-1:0] m_dv, m_rxer, m_rdy;
  logic [7:0]    m_rxd [NS];
  logic [15:0]   m_cnt [NS];

  assign m_dv   = {u_if2.rxdv[0], u_if.rxdv};
  assign m_rxer = {u_if2.rxer[0], u_if.rxer};
  assign m_rdy  = {u_if2.req_ready[0], u_if.req_ready};
  for (genvar g = 0; g < NP; g++) begin : g_mon
    assign m_rxd[g] = u_if.rxd[g];
    assign m_cnt[g] = u_if.frame_cnt[g];
  end
  assign m_rxd[4] = u_if2.rxd[0];
  assign m_cnt[4] = {14'd0, u_if2.frame_cnt[0]};

  logic [8:0] exp_q [NS][$];
  frm_t       frm_q [NS][$];

  int n_cmp  = 0;
  int n_fail = 0;

  bit mon_en = 1'b0, chk_rst = 1'b0, chk_align = 1'b0, chk_gap = 1'b0, to_req = 1'b0;

  int          run_len [NS];
  logic [31:0] run_crc [NS];
  bit          prev_dv [NS];
  int          exp_cnt [NS];
  int          gap;
  bit          gap_seen;
  logic [8:0]  mon_e;
  frm_t        mon_f;

  function automatic void chk(string nm, int p, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s port%0d: got 0x%0h expected 0x%0h", nm, p, act, exp);
    end
  endfunction

  function automatic logic [7:0] lfsr_model(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  function automatic void push_frame(int p, int len, int mode, logic [7:0] seed, bit bad, bit rx);
    int          l;
    logic [7:0]  pat;
    logic [31:0] crc, fcs;
    frm_t        f;
    l   = (len < 60) ? 60 : ((len > 1514) ? 1514 : len);
    pat = ((mode == 1) && (seed == 8'h00)) ? 8'h01 : seed;
    crc = CRC_INIT;
    for (int i = 0; i < 7; i++) exp_q[p].push_back({1'b0, 8'h55});
    exp_q[p].push_back({1'b0, 8'hD5});
    for (int i = 0; i < l; i++) begin
      exp_q[p].push_back({(i == 0) && rx, pat});
      crc = crc32_byte(crc, pat);
      pat = (mode == 1) ? lfsr_model(pat) : ((mode == 2) ? pat : pat + 8'd1);
    end
    fcs = ~crc;
    if (bad) fcs[24] = ~fcs[24];
    for (int b = 0; b < 4; b++) exp_q[p].push_back({1'b0, fcs[8*b +: 8]});
    f.len  = 32'(l + 12);
    f.good = !bad;
    frm_q[p].push_back(f);
  endfunction

  function automatic bit qs_empty();
    for (int p = 0; p < NS; p++) begin
      if (exp_q[p].size() != 0 || frm_q[p].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // monitor: pops the scoreboard and checks every output cycle
  always @(negedge clk) begin
    if (to_req) chk("wait_timeout", 0, 32'd1, 32'd0);
    if (!mon_en) begin
      for (int p = 0; p < NS; p++) begin
        exp_q[p].delete();
        frm_q[p].delete();
        run_len[p] = 0;
        prev_dv[p] = 1'b0;
        exp_cnt[p] = 0;
      end
      gap_seen = 1'b0;
    end else begin
      for (int p = 0; p < NS; p++) begin
        if (m_dv[p]) begin
          if (exp_q[p].size() == 0) begin
            chk("unexpected_byte", p, {23'd0, m_rxer[p], m_rxd[p]}, 32'h1FF);
          end else begin
            mon_e = exp_q[p].pop_front();
            chk("rxd", p, {24'd0, m_rxd[p]}, {24'd0, mon_e[7:0]});
            chk("rxer", p, {31'd0, m_rxer[p]}, {31'd0, mon_e[8]});
          end
          if (run_len[p] == 0) run_crc[p] = CRC_INIT;
          if (run_len[p] >= 8) run_crc[p] = crc32_byte(run_crc[p], m_rxd[p]);
          run_len[p]++;
        end else begin
          chk("idle_bus", p, {23'd0, m_rxer[p], m_rxd[p]}, 32'd0);
          if (prev_dv[p]) begin
            if (frm_q[p].size() == 0) begin
              chk("unexpected_frame", p, 32'(run_len[p]), 32'd0);
            end else begin
              mon_f = frm_q[p].pop_front();
              chk("rxdv_len", p, 32'(run_len[p]), mon_f.len);
              chk("fcs_residue_ok", p, {31'd0, run_crc[p] == CRC_RESIDUE}, {31'd0, mon_f.good});
            end
            exp_cnt[p]++;
            chk("frame_cnt", p, {16'd0, m_cnt[p]},
                32'(exp_cnt[p]) & ((p == 4) ? 32'h3 : 32'hFFFF));
            run_len[p] = 0;
          end
        end
        prev_dv[p] = m_dv[p];
      end
      if (chk_rst) begin
        for (int p = 0; p < NS; p++) begin
          chk("rst_ready", p, {31'd0, m_rdy[p]}, 32'd1);
          chk("rst_rxdv", p, {31'd0, m_dv[p]}, 32'd0);
          chk("rst_frame_cnt", p, {16'd0, m_cnt[p]}, 32'd0);
        end
      end
      if (chk_align) begin
        for (int p = 1; p < NP; p++) begin
          chk("align", p, {23'd0, m_dv[p], m_rxd[p]}, {23'd0, m_dv[0], m_rxd[0]});
        end
      end
      if (chk_gap) begin
        gap++;
        if (m_rdy[0]) begin
          if (gap_seen) chk("accept_gap", 0, 32'(gap), 32'(GAP_EXP));
          gap_seen = 1'b1;
          gap      = 0;
        end
      end else begin
        gap_seen = 1'b0;
        gap      = 0;
      end
    end
  end

  task automatic drive(int p, bit v, int len, int mode, logic [7:0] seed, bit bad, bit rx);
    if (p < NP) begin
      u_if.req_valid[p]   = v;
      u_if.req_len[p]     = len[10:0];
      u_if.req_mode[p]    = mode[1:0];
      u_if.req_seed[p]    = seed;
      u_if.req_bad_fcs[p] = bad;
      u_if.req_rxer[p]    = rx;
    end else begin
      u_if2.req_valid[0]   = v;
      u_if2.req_len[0]     = len[10:0];
      u_if2.req_mode[0]    = mode[1:0];
      u_if2.req_seed[0]    = seed;
      u_if2.req_bad_fcs[0] = bad;
      u_if2.req_rxer[0]    = rx;
    end
  endtask

  task automatic send(int p, int len, int mode, logic [7:0] seed, bit bad, bit rx);
    int n = 0;
    push_frame(p, len, mode, seed, bad, rx);
    @(posedge clk); #1;
    drive(p, 1'b1, len, mode, seed, bad, rx);
    do begin
      @(negedge clk);
      n++;
    end while (!m_rdy[p] && n < 5000);
    if (!m_rdy[p]) to_req = 1'b1;
    @(posedge clk); #1;
    drive(p, 1'b0, len, mode, seed, bad, rx);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_rdy == 5'h1F && m_dv == 5'h00 && qs_empty()) && n < 4000);
    if (n >= 4000) to_req = 1'b1;
  endtask

  initial begin
    int n_acc;
    int n;
    for (int p = 0; p < NS; p++) drive(p, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; mon_en = 1'b1; chk_rst = 1'b1;
    @(posedge clk); #1 chk_rst = 1'b0;

    send(0, 60, 0, 8'h00, 1'b0, 1'b0);
    send(1, 5, 0, 8'h10, 1'b0, 1'b0);
    send(2, 2000, 3, 8'hFE, 1'b0, 1'b0);
    send(3, 60, 1, 8'h00, 1'b0, 1'b0);
    send(0, 64, 0, 8'h33, 1'b1, 1'b0);
    wait_idle();

    for (int p = 0; p < NP; p++) begin
      push_frame(p, 60, 2, 8'hA5, 1'b0, 1'b0);
      push_frame(p, 60, 2, 8'hA5, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 60, 2, 8'hA5, 1'b0, 1'b0);
    chk_align = 1'b1;
    chk_gap   = 1'b1;
    n_acc = 0;
    n     = 0;
    while (n_acc < 2 && n < 1000) begin
      @(negedge clk);
      n++;
      if (m_rdy[0]) n_acc++;
    end
    if (n_acc < 2) to_req = 1'b1;
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 60, 2, 8'hA5, 1'b0, 1'b0);
    chk_gap = 1'b0;
    wait_idle();
    chk_align = 1'b0;

    send(1, 61, 3, 8'hF0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send(4, 60, 0, 8'(i * 17), 1'b0, 1'b0);
    wait_idle();

    send(0, 100, 0, 8'h00, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1 mon_en = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; mon_en = 1'b1; chk_rst = 1'b1;
    @(posedge clk); #1 chk_rst = 1'b0;
    send(0, 60, 0, 8'h20, 1'b0, 1'b0);
    send(2, 60, 1, 8'h5A, 1'b0, 1'b1);
    wait_idle();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
